// File: rtl/iohub_pkg.sv
// Shared iohub link definitions: frame marker, frame lengths and TX state encoding.
// Used by both the Atlys-to-PC transmit control and the PC-to-Atlys decoder.
package iohub_pkg;

  localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'h80;

  localparam int FRAME_LEN_BASE = 3;
  localparam int FRAME_LEN_CSUM = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/header_tx_control_if.sv
// Outbound FIFO read port plus UART TX byte interface of the iohub transmit path.
// master = frame controller, slave = FIFO/UART side.
interface header_tx_control_if;
  import iohub_pkg::*;

  logic        fifo_empty;
  logic [15:0] fifo_dout;
  logic        fifo_rd_en;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_byte;

  modport master (
    input  fifo_empty, fifo_dout, tx_busy, tx_done,
    output fifo_rd_en, tx_start, tx_byte
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_busy, tx_done,
    input  fifo_rd_en, tx_start, tx_byte
  );

endinterface

// File: rtl/header_tx_control.sv
// Pops 16-bit words from the outbound FIFO and sends each as header, high, low byte.
// Define HEADER_TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module header_tx_control
  import iohub_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE = HEADER_BYTE_DEFAULT,
  parameter int         GAP_CYCLES  = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  header_tx_control_if.master  bus,
  output logic                 busy_o,
  output logic [15:0]          frames_sent_o
);

`ifdef HEADER_TX_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam bit         HAS_GAP  = (GAP_CYCLES != 0);

  tx_state_e   state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  logic [15:0] frames_q, frames_d;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] word);
    case (idx)
      2'd0:    frame_byte = HEADER_BYTE;
      2'd1:    frame_byte = word[15:8];
      2'd2:    frame_byte = word[7:0];
`ifdef HEADER_TX_CHECKSUM_EN
      default: frame_byte = HEADER_BYTE ^ word[15:8] ^ word[7:0];
`else
      default: frame_byte = 8'h00;
`endif
    endcase
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      word_q   <= 16'h0000;
      idx_q    <= 2'd0;
      gap_q    <= 8'd0;
      frames_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    frames_d       = frames_q;
    bus.fifo_rd_en = 1'b0;
    bus.tx_start   = 1'b0;
    bus.tx_byte    = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_empty && !bus.tx_busy) begin
          bus.fifo_rd_en = 1'b1;
          state_d        = FETCH;
        end
      end
      FETCH: begin
        word_d  = bus.fifo_dout;
        idx_d   = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        bus.tx_byte = frame_byte(idx_q, word_q);
        // The UART may still be shifting; hold the byte and retry next cycle.
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        bus.tx_byte = frame_byte(idx_q, word_q);
        if (bus.tx_done) begin
          gap_d = 8'd0;
          if (idx_q == LAST_IDX) begin
            idx_d    = 2'd0;
            frames_d = frames_q + 16'd1;
            state_d  = HAS_GAP ? GAP : IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = HAS_GAP ? GAP : SEND;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        // idx_q wraps to 0 only after the last byte, so it tells where the gap leads.
        if (gap_q == GAP_LAST) state_d = (idx_q == 2'd0) ? IDLE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q != IDLE);
  assign frames_sent_o = frames_q;

endmodule

// File: tb/tb_header_tx_control.sv
// Bench for header_tx_control: two instances (GAP_CYCLES 0 and 5) fed the same words,
// each with its own FIFO/UART model and a frame-level reference model checked every cycle.
module tb_header_tx_control;

  localparam int UART_L = 4;
`ifdef HEADER_TX_CHECKSUM_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 3;
`endif
  localparam logic [7:0] HDR = 8'h80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  logic [15:0] fifo_q [2][$];
  logic [7:0]  log_q  [2][$];
  logic [7:0]  exp_lit [$];
  logic        busy_w   [2];
  logic [15:0] frames_w [2];
  logic        rd_w     [2];
  logic        start_w  [2];
  logic [7:0]  byte_w   [2];
  bit          model_idle [2];
  bit          stray_req  [2];
  bit          force_req  [2];
  int          gap_min [2];
  int          gap_max [2];
  int unsigned rd_cnt  [2];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int G = (g == 0) ? 0 : 5;

    header_tx_control_if ifc ();

    header_tx_control #(.HEADER_BYTE(HDR), .GAP_CYCLES(G)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .bus           (ifc),
      .busy_o        (busy_w[g]),
      .frames_sent_o (frames_w[g])
    );

    assign rd_w[g]    = ifc.fifo_rd_en;
    assign start_w[g] = ifc.tx_start;
    assign byte_w[g]  = ifc.tx_byte;

    initial begin : model
      int unsigned pops, dones, gap_left, force_cnt, due_cyc, u_start, rd_cyc, done_cyc;
      bit          byte_flight, byte_due, uart_act, gap_armed, force_chk, cur_gen;
      bit          nx_busy, nx_force, nx_done, nx_gen, nx_empty;
      bit          s_rd, s_start, s_busy, s_done, s_empty, exp_busy, exp_rd, exp_start;
      logic [7:0]  s_byte, cur_exp;
      logic [7:0]  exp_q [$];
      logic [15:0] w, nx_dout;
      pops = 0; dones = 0; gap_left = 0; force_cnt = 0; due_cyc = 0; u_start = 0;
      rd_cyc = 0; done_cyc = 0; byte_flight = 0; byte_due = 0; uart_act = 0;
      gap_armed = 0; force_chk = 0; cur_gen = 0; cur_exp = 8'h00; nx_dout = 16'h0000;
      nx_busy = 0; nx_force = 0; nx_done = 0; nx_gen = 0; nx_empty = 1;
      ifc.fifo_empty = 1'b1; ifc.fifo_dout = 16'h0000;
      ifc.tx_busy = 1'b0; ifc.tx_done = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          chk($sformatf("u%0d_rst_rd", g), ifc.fifo_rd_en, 0);
          chk($sformatf("u%0d_rst_start", g), ifc.tx_start, 0);
          chk($sformatf("u%0d_rst_byte", g), ifc.tx_byte, 0);
          chk($sformatf("u%0d_rst_busy", g), busy_w[g], 0);
          chk($sformatf("u%0d_rst_frames", g), frames_w[g], 0);
          pops = 0; dones = 0; gap_left = 0; force_cnt = 0; byte_flight = 0; byte_due = 0;
          uart_act = 0; gap_armed = 0; force_chk = 0;
          exp_q.delete(); fifo_q[g].delete();
          nx_busy = 0; nx_force = 0; nx_done = 0; nx_gen = 0; nx_empty = 1;
          model_idle[g] = 1;
        end else begin
          s_rd = ifc.fifo_rd_en; s_start = ifc.tx_start; s_busy = ifc.tx_busy;
          s_done = ifc.tx_done; s_empty = ifc.fifo_empty; s_byte = ifc.tx_byte;
          exp_busy  = (pops * FLEN > dones) || (gap_left > 0);
          exp_rd    = !exp_busy && !s_empty && !s_busy;
          exp_start = byte_due && (cyc >= due_cyc) && !s_busy;
          chk($sformatf("u%0d_busy", g), busy_w[g], exp_busy);
          chk($sformatf("u%0d_rd_en", g), s_rd, exp_rd);
          chk($sformatf("u%0d_tx_start", g), s_start, exp_start);
          chk($sformatf("u%0d_frames", g), frames_w[g], 16'(dones / FLEN));
          if (byte_flight) chk($sformatf("u%0d_byte_hold", g), s_byte, cur_exp);
          if (s_start) begin
            chk($sformatf("u%0d_start_while_busy", g), s_busy, 0);
            if (exp_q.size() > 0) chk($sformatf("u%0d_tx_byte", g), s_byte, exp_q[0]);
          end

          if (gap_left > 0) gap_left--;
          if (s_done && cur_gen) begin
            dones++; byte_flight = 0; done_cyc = cyc;
            if (dones % FLEN == 0) begin
              gap_left  = G;
              gap_armed = (fifo_q[g].size() > 0);
            end else begin
              byte_due = 1; due_cyc = cyc + 1 + G; gap_armed = 1;
            end
          end
          if ((s_start || s_rd) && gap_armed) begin
            gap_armed = 0;
            if (int'(cyc - done_cyc - 1) < gap_min[g]) gap_min[g] = int'(cyc - done_cyc - 1);
            if (int'(cyc - done_cyc - 1) > gap_max[g]) gap_max[g] = int'(cyc - done_cyc - 1);
          end
          if (s_start) begin
            log_q[g].push_back(s_byte);
            if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
            byte_flight = 1; byte_due = 0; uart_act = 1; u_start = cyc;
            if (force_chk) begin
              chk($sformatf("u%0d_stall_latency", g), cyc - rd_cyc, 21);
              force_chk = 0;
            end
          end
          if (s_rd) begin
            w = (fifo_q[g].size() > 0) ? fifo_q[g].pop_front() : 16'hxxxx;
            exp_q.push_back(HDR); exp_q.push_back(w[15:8]); exp_q.push_back(w[7:0]);
`ifdef HEADER_TX_CHECKSUM_EN
            exp_q.push_back(HDR ^ w[15:8] ^ w[7:0]);
`endif
            pops++; rd_cnt[g]++; rd_cyc = cyc; byte_due = 1; due_cyc = cyc + 2;
            nx_dout = w;
            if (force_req[g]) begin force_req[g] = 0; force_cnt = 20; force_chk = 1; end
          end

          nx_force = (force_cnt > 0);
          if (force_cnt > 0) force_cnt--;
          nx_busy = 0; nx_done = 0; nx_gen = 0;
          if (uart_act) begin
            if (cyc + 1 <= u_start + UART_L) nx_busy = 1;
            else begin nx_done = 1; nx_gen = 1; uart_act = 0; end
          end
          if (stray_req[g]) begin stray_req[g] = 0; nx_done = 1; end
          nx_empty = (fifo_q[g].size() == 0);
          model_idle[g] = (pops * FLEN == dones) && (gap_left == 0) && !uart_act && !byte_due;
        end
        @(posedge clk); #1;
        ifc.tx_busy    = nx_busy | nx_force;
        ifc.tx_done    = nx_done;
        cur_gen        = nx_gen;
        ifc.fifo_dout  = nx_dout;
        ifc.fifo_empty = nx_empty;
      end
    end
  end

  task automatic push(input logic [15:0] w);
    fifo_q[0].push_back(w);
    fifo_q[1].push_back(w);
  endtask

  task automatic add_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d);
    exp_lit.push_back(a); exp_lit.push_back(b); exp_lit.push_back(c);
`ifdef HEADER_TX_CHECKSUM_EN
    exp_lit.push_back(d);
`else
    if (d === 8'hxx) exp_lit.push_back(d);
`endif
  endtask

  task automatic check_log(input string name);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d_%s_len", g, name), log_q[g].size(), exp_lit.size());
      for (int i = 0; i < exp_lit.size() && i < log_q[g].size(); i++)
        chk($sformatf("u%0d_%s_b%0d", g, name, i), log_q[g][i], exp_lit[i]);
    end
  endtask

  task automatic clear_logs();
    log_q[0].delete(); log_q[1].delete(); exp_lit.delete();
    rd_cnt[0] = 0; rd_cnt[1] = 0;
    gap_min[0] = 1000; gap_min[1] = 1000; gap_max[0] = -1; gap_max[1] = -1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #2;
      if (fifo_q[0].size() == 0 && fifo_q[1].size() == 0 && model_idle[0] && model_idle[1] &&
          !busy_w[0] && !busy_w[1]) break;
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    stray_req[0] = 0; stray_req[1] = 0; force_req[0] = 0; force_req[1] = 0;
    clear_logs();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d_init_busy", g), busy_w[g], 0);
      chk($sformatf("u%0d_init_frames", g), frames_w[g], 0);
      chk($sformatf("u%0d_init_byte", g), byte_w[g], 0);
    end
    rst = 1'b0;

    // single word 1234
    push(16'h1234);
    wait_idle();
    add_frame(8'h80, 8'h12, 8'h34, 8'hA6);
    check_log("w1234");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d_w1234_frames", g), frames_w[g], 1);
      chk($sformatf("u%0d_w1234_pops", g), rd_cnt[g], 1);
    end

    // three words back to back, gaps measured
    do_reset();
    clear_logs();
    push(16'hAAAA); push(16'h0080); push(16'hFFFF);
    wait_idle();
    add_frame(8'h80, 8'hAA, 8'hAA, 8'h80);
    add_frame(8'h80, 8'h00, 8'h80, 8'h00);
    add_frame(8'h80, 8'hFF, 8'hFF, 8'h80);
    check_log("w3");
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d_w3_frames", g), frames_w[g], 3);
      chk($sformatf("u%0d_w3_pops", g), rd_cnt[g], 3);
    end
    chk("u0_gap_min", gap_min[0], 0);
    chk("u0_gap_max", gap_max[0], 0);
    chk("u1_gap_min", gap_min[1], 5);
    chk("u1_gap_max", gap_max[1], 5);

    // stray tx_done while idle
    stray_req[0] = 1; stray_req[1] = 1;
    repeat (6) @(posedge clk);
    #2;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d_stray_frames", g), frames_w[g], 3);
      chk($sformatf("u%0d_stray_busy", g), busy_w[g], 0);
      chk($sformatf("u%0d_stray_pops", g), rd_cnt[g], 3);
    end

    // tx_busy held high for 20 cycles across SEND
    clear_logs();
    force_req[0] = 1; force_req[1] = 1;
    push(16'h5566);
    wait_idle();
    add_frame(8'h80, 8'h55, 8'h66, 8'hB3);
    check_log("stall");
    for (int g = 0; g < 2; g++) chk($sformatf("u%0d_stall_frames", g), frames_w[g], 4);

    // reset just after the header byte of BEEF
    clear_logs();
    push(16'hBEEF);
    n = 0;
    while (log_q[0].size() == 0 && n < 200) begin @(posedge clk); #2; n++; end
    if (n >= 200) chk("beef_header_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("u%0d_abort_busy", g), busy_w[g], 0);
      chk($sformatf("u%0d_abort_frames", g), frames_w[g], 0);
      chk($sformatf("u%0d_abort_rd", g), rd_w[g], 0);
      chk($sformatf("u%0d_abort_start", g), start_w[g], 0);
      chk($sformatf("u%0d_abort_byte", g), byte_w[g], 0);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    exp_lit.push_back(8'h80);
    check_log("beef_partial");
    clear_logs();
    push(16'h0102);
    wait_idle();
    add_frame(8'h80, 8'h01, 8'h02, 8'h83);
    check_log("after_rst");
    for (int g = 0; g < 2; g++) chk($sformatf("u%0d_after_rst_frames", g), frames_w[g], 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
